train_seq: RTL

- Training sequencer and parameter store that sits directly downstream of the backprop stage and drives its we/dtb controls.
- Per accepted sample, it waits for the forward path to settle, then issues one accumulate cycle.
- After batch_size samples, it walks a one-hot write-back over every parameter slot and captures each updated value from the shared bus into its register file.
- It re-exports the stored parameters as packed wall/ball for the forward network.

---
 rtl/train_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/train_seq.sv
// Training sequencer and parameter store: paces accumulate cycles per sample,
// walks a one-hot write-back over all slots per batch and re-exports the parameters.
module train_seq #(
    parameter int            N         = 32,
    parameter int            WT        = 12,
    parameter int            ND        = 5,
    parameter int            S         = WT + ND,
    parameter logic [S-1:0]  BIAS_MASK = 17'h11124,
    parameter int            SETTLE    = 2,
    parameter int            AW        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       batch_size,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              init_we,
    input  logic [AW-1:0]     init_addr,
    input  logic [N-1:0]      init_data,
    output logic [S-1:0]      we,
    output logic              dtb,
    input  logic [2*N-1:0]    bus,
    output logic              acc_clr,
    output logic [N*WT-1:0]   wall,
    output logic [N*ND-1:0]   ball,
    output logic              epoch_done,
    output logic              busy
);

    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACC,
        ST_WB,
        ST_DONE
    } state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  timer, timer_nx;
    logic [15:0]    count, count_nx;
    logic [15:0]    bs, bs_nx;
    logic [AW-1:0]  slot, slot_nx;
    logic [N-1:0]   param [S];

    logic [S-1:0]   we_nx;
    logic           dtb_nx;
    logic           acc_clr_nx;
    logic           epoch_done_nx;
    logic           init_ok;

    // Only the low half of the bus carries the updated value.
    logic           unused_bus_hi;
    assign unused_bus_hi = ^bus[2*N-1:N];

    assign init_ok = init_we && (count == '0) && (int'(init_addr) < S);

    // Position of slot k among the slots of the same kind (weight or bias).
    function automatic int unsigned rank(input int unsigned k, input logic b);
        int unsigned r;
        r = 0;
        for (int unsigned j = 0; j < k; j++)
            if (BIAS_MASK[j] == b) r++;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            count      <= '0;
            bs         <= 16'd1;
            slot       <= '0;
            we         <= '0;
            dtb        <= 1'b0;
            acc_clr    <= 1'b0;
            epoch_done <= 1'b0;
            for (int unsigned i = 0; i < S; i++)
                param[i] <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            count      <= count_nx;
            bs         <= bs_nx;
            slot       <= slot_nx;
            we         <= we_nx;
            dtb        <= dtb_nx;
            acc_clr    <= acc_clr_nx;
            epoch_done <= epoch_done_nx;
            if (state == ST_IDLE && init_ok)
                param[init_addr] <= init_data;
            else if (state == ST_WB)
                param[slot] <= bus[N-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        count_nx = count;
        bs_nx    = bs;
        slot_nx  = slot;
        case (state)
            ST_IDLE: begin
                if (s_valid && !init_we) begin
                    if (count == '0)
                        bs_nx = (batch_size == '0) ? 16'd1 : batch_size;
                    if (SETTLE == 0) begin
                        state_nx = ST_ACC;
                    end else begin
                        state_nx = ST_SETTLE;
                        timer_nx = TW'(SETTLE - 1);
                    end
                end
            end
            ST_SETTLE: begin
                if (timer == '0)
                    state_nx = ST_ACC;
                else
                    timer_nx = timer - 1'b1;
            end
            ST_ACC: begin
                if (count + 16'd1 == bs) begin
                    count_nx = '0;
                    slot_nx  = '0;
                    state_nx = ST_WB;
                end else begin
                    count_nx = count + 16'd1;
                    state_nx = ST_IDLE;
                end
            end
            ST_WB: begin
                slot_nx = slot + 1'b1;
                if (slot == AW'(S - 1))
                    state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Registered controls are decoded from the next state so they line up with it.
    always_comb begin
        s_ready       = (state == ST_IDLE) && !init_we;
        busy          = (state != ST_IDLE);
        we_nx         = '0;
        dtb_nx        = 1'b0;
        acc_clr_nx    = 1'b0;
        epoch_done_nx = 1'b0;
        case (state_nx)
            ST_ACC: we_nx = '1;
            ST_WB: begin
                we_nx  = S'(1) << slot_nx;
                dtb_nx = 1'b1;
            end
            ST_DONE: begin
                acc_clr_nx    = 1'b1;
                epoch_done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < S; k++) begin : g_pack
        localparam int unsigned R = rank(k, BIAS_MASK[k]);
        if (BIAS_MASK[k]) begin : g_bias
            assign ball[R*N +: N] = param[k];
        end else begin : g_weight
            assign wall[R*N +: N] = param[k];
        end
    end

endmodule
